// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter
// Shares one Scratch_Memory_Controller (write port A, read port B) among
// NUM_REQ FSM requesters using round-robin arbitration with a locking grant.
// The owner keeps the memory until it drops its request. A hold-time watchdog
// revokes a grant held for MAX_HOLD cycles. A test override hands the memory
// ports straight to the testbench.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   req            per-requester access request (bit i = requester i)
//   reqReadAddr    packed read addresses (slice i = requester i)
//   reqWriteAddr   packed write addresses
//   reqWriteData   packed write data
//   reqWriteEn     per-requester write enable
//   grant          one-hot registered grant
//   testMuxSel     test override select
//   testReadAddr   test read address
//   testWriteAddr  test write address
//   testMemOut     test write data
//   testMemWriteEn test write enable
//   memReadAddr    to memory addrb
//   memWriteAddr   to memory addra
//   memWriteData   to memory dina
//   memWriteEn     to memory wea
//   busy           high while any grant is held
//   timeout        one-cycle pulse when the watchdog revokes a grant
//   timeoutId      index of the last revoked requester
module scratch_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 1024,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] reqReadAddr,
  input  logic [NUM_REQ*ADDR_W-1:0] reqWriteAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqWriteData,
  input  logic [NUM_REQ-1:0]        reqWriteEn,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      testMuxSel,
  input  logic [ADDR_W-1:0]         testReadAddr,
  input  logic [ADDR_W-1:0]         testWriteAddr,
  input  logic [DATA_W-1:0]         testMemOut,
  input  logic                      testMemWriteEn,
  output logic [ADDR_W-1:0]         memReadAddr,
  output logic [ADDR_W-1:0]         memWriteAddr,
  output logic [DATA_W-1:0]         memWriteData,
  output logic                      memWriteEn,
  output logic                      busy,
  output logic                      timeout,
  output logic [ID_W-1:0]           timeoutId
);

  typedef enum logic [1:0] {IDLE, OWNED, TEST} arbStateT;

  arbStateT           state;
  logic [ID_W-1:0]    lastGrant;
  logic [CNT_W-1:0]   holdCount;
  logic [NUM_REQ-1:0] revokeMask;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arbSet;
  logic [NUM_REQ-1:0] ownerBit;
  logic               atLimit;
  logic               revokeNow;
  logic               found;
  logic [ID_W-1:0]    winner;
  int                 idx;

  // Round-robin search. While OWNED, lastGrant is the current owner, so the
  // same search serves both a fresh arbitration and a same-edge handoff.
  // A requester being revoked this edge is removed from the candidate set.
  always_comb begin
    eligible  = req & ~revokeMask;
    ownerBit  = NUM_REQ'(1) << lastGrant;
    atLimit   = (holdCount == CNT_W'(MAX_HOLD - 1));
    revokeNow = (state == OWNED) && req[lastGrant] && atLimit;
    arbSet    = revokeNow ? (eligible & ~ownerBit) : eligible;
    found     = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(lastGrant) + 1 + k) % NUM_REQ;
      if (!found && arbSet[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Arbitration FSM. The test override preempts any owner without marking
  // it as revoked; the revoke mask only remembers watchdog victims until
  // they let go of their request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      lastGrant  <= ID_W'(NUM_REQ - 1);
      holdCount  <= '0;
      revokeMask <= '0;
      timeout    <= 1'b0;
      timeoutId  <= '0;
    end else begin
      timeout    <= 1'b0;
      revokeMask <= revokeMask & req;
      if (testMuxSel) begin
        grant <= '0;
        state <= TEST;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              grant     <= NUM_REQ'(1) << winner;
              lastGrant <= winner;
              holdCount <= '0;
              state     <= OWNED;
            end
          end
          OWNED: begin
            if (req[lastGrant] && !atLimit) begin
              holdCount <= holdCount + CNT_W'(1);
            end else begin
              if (revokeNow) begin
                revokeMask <= (revokeMask & req) | ownerBit;
                timeout    <= 1'b1;
                timeoutId  <= lastGrant;
              end
              if (found) begin
                grant     <= NUM_REQ'(1) << winner;
                lastGrant <= winner;
                holdCount <= '0;
              end else begin
                grant <= '0;
                state <= IDLE;
              end
            end
          end
          TEST: begin
            state <= IDLE;
          end
          default: begin
            grant <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Memory port mux. Driven from the registered grant, so only the owner's
  // write enable can ever reach the memory; the test override wins always.
  always_comb begin
    memReadAddr  = '0;
    memWriteAddr = '0;
    memWriteData = '0;
    memWriteEn   = 1'b0;
    if (testMuxSel) begin
      memReadAddr  = testReadAddr;
      memWriteAddr = testWriteAddr;
      memWriteData = testMemOut;
      memWriteEn   = testMemWriteEn;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          memReadAddr  = reqReadAddr[i*ADDR_W +: ADDR_W];
          memWriteAddr = reqWriteAddr[i*ADDR_W +: ADDR_W];
          memWriteData = reqWriteData[i*DATA_W +: DATA_W];
          memWriteEn   = reqWriteEn[i];
        end
      end
    end
  end

  assign busy = |grant;

  grantOneHot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));

endmodule
